// File: rtl/heartbeat_sched.sv
// Round-robin blink-code scheduler sharing one LED/status pin among R requesters.
// Define SC_HEARTBEAT_IDLE_EN to make out toggle on every tick while idle.
module heartbeat_sched #(
  parameter int R           = 4,
  parameter int CW          = 4,
  parameter int PW          = 8,
  parameter int ON_TICKS    = 1,
  parameter int OFF_TICKS   = 1,
  parameter int PAUSE_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [R-1:0]         req,
  input  logic [R*CW-1:0]      code,
  output logic [R-1:0]         ack,
  output logic                 busy,
  output logic [$clog2(R)-1:0] grant_id,
  output logic                 out
);

  localparam int GW     = $clog2(R);
  localparam int MAX_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_T  = (MAX_OO > PAUSE_TICKS) ? MAX_OO : PAUSE_TICKS;
  localparam int TW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_PAUSE} state_t;

  state_t         state;
  logic [PW-1:0]  presc;
  logic [TW-1:0]  timer;
  logic [CW-1:0]  cnt;
  logic [GW-1:0]  last;
  logic           tick;

  logic           found;
  logic [GW-1:0]  win;
  logic [GW-1:0]  idx;
  logic [CW-1:0]  win_code;

  assign tick     = &presc;
  assign win_code = code[int'(win)*CW +: CW];

  // Scan starts one past the last grant so every pending requester is served in turn.
  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= R; k++) begin
      idx = GW'((int'(last) + k) % R);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      presc    <= '0;
      timer    <= '0;
      cnt      <= '0;
      last     <= GW'(R - 1);
      grant_id <= '0;
      busy     <= 1'b0;
      ack      <= '0;
      out      <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      ack   <= '0;
      if (tick) begin
        unique case (state)
          S_IDLE: begin
            if (found) begin
              grant_id <= win;
              last     <= win;
              cnt      <= win_code;
              timer    <= '0;
              out      <= 1'b0;
              if (win_code == '0) begin
                // Zero code completes at once: ack next cycle, busy never seen high.
                ack  <= R'(1) << win;
                busy <= 1'b0;
              end else begin
                state <= S_ON;
                busy  <= 1'b1;
                out   <= 1'b1;
              end
            end else begin
`ifdef SC_HEARTBEAT_IDLE_EN
              out <= ~out;
`else
              out <= 1'b0;
`endif
            end
          end
          S_ON: begin
            if (timer == ON_LAST) begin
              timer <= '0;
              out   <= 1'b0;
              if (cnt != '0) cnt <= cnt - 1'b1;
              state <= (cnt <= CW'(1)) ? S_PAUSE : S_OFF;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_OFF: begin
            if (timer == OFF_LAST) begin
              timer <= '0;
              state <= S_ON;
              out   <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_PAUSE: begin
            if (timer == PAUSE_LAST) begin
              timer <= '0;
              state <= S_IDLE;
              busy  <= 1'b0;
              ack   <= R'(1) << grant_id;
              out   <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
